// File: rtl/backoff_slot_ctl.sv
// Random backoff controller: draws a slot count from a masked LFSR or override value,
// then waits an IFS period and counts idle slots down to a one-cycle completion pulse.
module backoff_slot_ctl #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          CW_EXP_CAP = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [3:0]  i_cw_exp,
  input  logic        i_ch_idle,
  input  logic [13:0] i_ifs_cycles,
  input  logic [9:0]  i_slot_cycles,
  input  logic        i_rand_ovr_en,
  input  logic [9:0]  i_rand_ovr_val,
  output logic        o_bo_done,
  output logic        o_bo_busy,
  output logic [9:0]  o_bo_slots,
  output logic [1:0]  o_bo_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_IFS = 2'd1,
    S_COUNT    = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [3:0] CAP_EXP = 4'(CW_EXP_CAP);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_lfsr;
  logic [13:0] r_ifs_cnt, w_ifs_cnt_nxt;
  logic [9:0]  r_slot_cnt, w_slot_cnt_nxt;
  logic [9:0]  r_slots, w_slots_nxt;

  logic [3:0]  w_exp;
  logic [9:0]  w_mask;
  logic [9:0]  w_draw;
  logic [13:0] w_ifs_last;
  logic [9:0]  w_slot_last;
  logic        w_lfsr_fb;

  assign w_exp       = (i_cw_exp > CAP_EXP) ? CAP_EXP : i_cw_exp;
  assign w_mask      = 10'((11'd1 << w_exp) - 11'd1);
  assign w_draw      = (i_rand_ovr_en ? i_rand_ovr_val : r_lfsr[9:0]) & w_mask;
  // A zero-length IFS or slot is treated as one cycle long.
  assign w_ifs_last  = (i_ifs_cycles == '0)  ? '0 : i_ifs_cycles - 14'd1;
  assign w_slot_last = (i_slot_cycles == '0) ? '0 : i_slot_cycles - 10'd1;
  assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_ifs_cnt_nxt  = r_ifs_cnt;
    w_slot_cnt_nxt = r_slot_cnt;
    w_slots_nxt    = r_slots;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_slots_nxt   = w_draw;
          w_ifs_cnt_nxt = '0;
          w_state_nxt   = S_WAIT_IFS;
        end
      end
      S_WAIT_IFS: begin
        if (!i_ch_idle) begin
          w_ifs_cnt_nxt = '0;
        end else if (r_ifs_cnt >= w_ifs_last) begin
          w_ifs_cnt_nxt  = '0;
          w_slot_cnt_nxt = '0;
          w_state_nxt    = (r_slots == '0) ? S_DONE : S_COUNT;
        end else begin
          w_ifs_cnt_nxt = r_ifs_cnt + 14'd1;
        end
      end
      S_COUNT: begin
        if (!i_ch_idle) begin
          // Busy medium discards the partial slot and demands a fresh IFS.
          w_ifs_cnt_nxt  = '0;
          w_slot_cnt_nxt = '0;
          w_state_nxt    = S_WAIT_IFS;
        end else if (r_slot_cnt >= w_slot_last) begin
          w_slot_cnt_nxt = '0;
          if (r_slots != '0) w_slots_nxt = r_slots - 10'd1;
          if (r_slots <= 10'd1) w_state_nxt = S_DONE;
        end else begin
          w_slot_cnt_nxt = r_slot_cnt + 10'd1;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort overrides everything above but leaves the slot count visible.
    if (i_abort) begin
      w_state_nxt    = S_IDLE;
      w_ifs_cnt_nxt  = '0;
      w_slot_cnt_nxt = '0;
      w_slots_nxt    = r_slots;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_lfsr     <= LFSR_SEED;
      r_ifs_cnt  <= '0;
      r_slot_cnt <= '0;
      r_slots    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lfsr     <= {w_lfsr_fb, r_lfsr[15:1]};
      r_ifs_cnt  <= w_ifs_cnt_nxt;
      r_slot_cnt <= w_slot_cnt_nxt;
      r_slots    <= w_slots_nxt;
    end
  end

  assign o_bo_done  = rstn && (r_state == S_DONE) && !i_abort;
  assign o_bo_busy  = (r_state != S_IDLE);
  assign o_bo_slots = r_slots;
  assign o_bo_state = r_state;

endmodule

// File: tb/tb_backoff_slot_ctl.sv
// Directed bench for backoff_slot_ctl: expected completions are queued at start and
// matched by an independent monitor on every bo_done pulse.
module tb_backoff_slot_ctl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_start, i_abort, i_ch_idle, i_rand_ovr_en;
  logic [3:0]  i_cw_exp;
  logic [13:0] i_ifs_cycles;
  logic [9:0]  i_slot_cycles, i_rand_ovr_val;
  logic        o_bo_done, o_bo_busy;
  logic [9:0]  o_bo_slots;
  logic [1:0]  o_bo_state;

  typedef struct {
    int start_cyc;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   c0  = 0;
  int   checks = 0;
  int   errors = 0;

  backoff_slot_ctl dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_cw_exp      (i_cw_exp),
    .i_ch_idle     (i_ch_idle),
    .i_ifs_cycles  (i_ifs_cycles),
    .i_slot_cycles (i_slot_cycles),
    .i_rand_ovr_en (i_rand_ovr_en),
    .i_rand_ovr_val(i_rand_ovr_val),
    .o_bo_done     (o_bo_done),
    .o_bo_busy     (o_bo_busy),
    .o_bo_slots    (o_bo_slots),
    .o_bo_state    (o_bo_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle start; lat > 0 queues the expected start-to-done latency.
  task automatic start_bo(input logic ovr_en, input logic [9:0] val, input logic [3:0] cw,
                          input logic [13:0] ifs, input logic [9:0] slot, input int lat);
    exp_t e;
    i_rand_ovr_en  = ovr_en;
    i_rand_ovr_val = val;
    i_cw_exp       = cw;
    i_ifs_cycles   = ifs;
    i_slot_cycles  = slot;
    i_start        = 1'b1;
    c0             = cyc;
    if (lat > 0) begin
      e.start_cyc = c0;
      e.lat       = lat;
      sb_q.push_back(e);
    end
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic abort_now();
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn && o_bo_done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'(o_bo_done), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("done_latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
        check("done_state", 32'(o_bo_state), 32'd3);
      end
    end
  end

  initial begin
    rstn = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_ch_idle = 1'b1;
    i_rand_ovr_en = 1'b0; i_rand_ovr_val = '0; i_cw_exp = '0;
    i_ifs_cycles = 14'd5; i_slot_cycles = 10'd4;
    tick(3);
    check("rst_state", 32'(o_bo_state), 32'd0);
    check("rst_busy",  32'(o_bo_busy),  32'd0);
    check("rst_done",  32'(o_bo_done),  32'd0);
    check("rst_slots", 32'(o_bo_slots), 32'd0);

    // First draw after reset takes the seed: 0xACE1 & 0x3FF.
    rstn = 1'b1;
    start_bo(1'b0, 10'd0, 4'd10, 14'd5, 10'd4, 0);
    check("seed_draw", 32'(o_bo_slots), 32'h0E1);
    check("seed_state", 32'(o_bo_state), 32'd1);
    abort_now();
    check("abort_wait_state", 32'(o_bo_state), 32'd0);
    check("abort_wait_hold", 32'(o_bo_slots), 32'h0E1);

    // Nominal run: 3 slots of 4 after a 5-cycle IFS.
    start_bo(1'b1, 10'd3, 4'd4, 14'd5, 10'd4, 19);
    check("nom_wait", 32'(o_bo_state), 32'd1);
    check("nom_slots0", 32'(o_bo_slots), 32'd3);
    tick(5);
    check("nom_count", 32'(o_bo_state), 32'd2);
    check("nom_slots3", 32'(o_bo_slots), 32'd3);
    tick(4);
    check("nom_slots2", 32'(o_bo_slots), 32'd2);
    tick(4);
    check("nom_slots1", 32'(o_bo_slots), 32'd1);
    tick(4);
    check("nom_done_state", 32'(o_bo_state), 32'd3);
    check("nom_slots_end", 32'(o_bo_slots), 32'd0);
    tick(1);
    check("nom_idle", 32'(o_bo_state), 32'd0);
    check("nom_busy", 32'(o_bo_busy), 32'd0);

    // Mask and exponent cap.
    start_bo(1'b1, 10'h3FF, 4'd2, 14'd5, 10'd4, 0);
    check("mask_e2", 32'(o_bo_slots), 32'd3);
    abort_now();
    start_bo(1'b1, 10'h3FF, 4'd15, 14'd5, 10'd4, 0);
    check("mask_cap", 32'(o_bo_slots), 32'h3FF);
    abort_now();

    // Zero slots: IFS straight to DONE.
    start_bo(1'b1, 10'd0, 4'd4, 14'd5, 10'd4, 7);
    tick(4);
    check("zero_wait", 32'(o_bo_state), 32'd1);
    tick(1);
    check("zero_done", 32'(o_bo_state), 32'd3);
    tick(1);
    check("zero_idle", 32'(o_bo_state), 32'd0);

    // Busy medium mid-slot restarts IFS and the slot.
    start_bo(1'b1, 10'd2, 4'd4, 14'd3, 10'd4, 19);
    tick(4);
    i_ch_idle = 1'b0;
    tick(1);
    check("busy_wait", 32'(o_bo_state), 32'd1);
    check("busy_hold", 32'(o_bo_slots), 32'd2);
    tick(1);
    i_ch_idle = 1'b1;
    tick(3);
    check("busy_recount", 32'(o_bo_state), 32'd2);
    check("busy_slots2", 32'(o_bo_slots), 32'd2);
    tick(4);
    check("busy_slots1", 32'(o_bo_slots), 32'd1);
    tick(5);
    check("busy_idle", 32'(o_bo_state), 32'd0);

    // Abort in COUNT, then abort together with start.
    start_bo(1'b1, 10'd2, 4'd4, 14'd1, 10'd3, 0);
    tick(2);
    check("abort_pre", 32'(o_bo_state), 32'd2);
    abort_now();
    check("abort_cnt_state", 32'(o_bo_state), 32'd0);
    check("abort_cnt_slots", 32'(o_bo_slots), 32'd2);
    i_abort = 1'b1;
    start_bo(1'b1, 10'd5, 4'd4, 14'd1, 10'd3, 0);
    i_abort = 1'b0;
    check("abort_start", 32'(o_bo_state), 32'd0);
    check("abort_start_slots", 32'(o_bo_slots), 32'd2);

    // Zero-length IFS and slot behave as one cycle each.
    start_bo(1'b1, 10'd2, 4'd4, 14'd0, 10'd0, 5);
    check("z1_wait", 32'(o_bo_state), 32'd1);
    tick(2);
    check("z1_count", 32'(o_bo_state), 32'd2);
    check("z1_slots", 32'(o_bo_slots), 32'd1);
    tick(1);
    check("z1_done", 32'(o_bo_state), 32'd3);
    tick(1);

    // Reset mid-COUNT, then the LFSR restarts from the seed.
    start_bo(1'b1, 10'd3, 4'd4, 14'd1, 10'd4, 0);
    tick(2);
    rstn = 1'b0;
    tick(1);
    check("mrst_state", 32'(o_bo_state), 32'd0);
    check("mrst_busy",  32'(o_bo_busy),  32'd0);
    check("mrst_done",  32'(o_bo_done),  32'd0);
    check("mrst_slots", 32'(o_bo_slots), 32'd0);
    tick(1);
    rstn = 1'b1;
    tick(1);
    start_bo(1'b0, 10'd0, 4'd10, 14'd5, 10'd4, 0);
    check("lfsr_step1", 32'(o_bo_slots), 32'h270);
    abort_now();

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1);
    check("pending_done", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
